control_multi: RTL and testbench

CONTROL_MULTI -- requirements
Module: control_multi

---
 rtl/control_multi.sv | 221 ++++++++++++++++++++++
 tb/tb_control_multi.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_multi.sv
// control_multi: multicycle MIPS-subset control unit (R-type, lw, sw, beq, j, addi).
// Moore FSM; every datapath control is decoded from the current state and the
// memory wait counter. Memory accesses (FETCH, MEMRD, MEMWR) stretch over
// MEM_WAIT extra cycles before the state may advance.
//
// Ports:
//   clk, reset           sole clock, synchronous active-high reset
//   opcode[5:0]          IR[31:26], looked at only in DECODE
//   PCWrite .. RegDst    single-bit datapath controls
//   ALUOp, ALUSrcB, PCSource  2-bit datapath selects
//   state[3:0]           current state code (debug)
//   instr_done           high in the final cycle of each completed instruction
//   illegal              high while parked in ILLEGAL
//
// state   | meaning
// --------+-----------------------------------------------
// FETCH   | read instruction, PC+4 (last wait cycle writes IR/PC)
// DECODE  | register read, branch target computed
// MEMADR  | effective address for lw/sw
// MEMRD   | data memory read (waits MEM_WAIT)
// MEMWB   | load result to register file
// MEMWR   | data memory write (waits MEM_WAIT)
// EXEC    | R-type ALU operation
// RCOMP   | R-type result to rd
// BRANCH  | beq compare and conditional PC write
// JUMP    | jump target to PC
// ADDI_EX | rs + sign-extended immediate
// ADDI_WB | addi result to rt
// ILLEGAL | unknown opcode, parked until reset
module control_multi #(
    parameter int MEM_WAIT = 0,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RCOMP   = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDI_EX = 4'd10,
        S_ADDI_WB = 4'd11,
        S_ILLEGAL = 4'd12
    } state_t;

    localparam logic [5:0]       OP_RTYPE  = 6'd0;
    localparam logic [5:0]       OP_LW     = 6'd35;
    localparam logic [5:0]       OP_SW     = 6'd43;
    localparam logic [5:0]       OP_BEQ    = 6'd4;
    localparam logic [5:0]       OP_J      = 6'd2;
    localparam logic [5:0]       OP_ADDI   = 6'd8;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_WAIT);

    state_t           cur, nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             wait_last;
    logic             is_lw;
    logic             wait_state;

    assign wait_last  = (cnt == WAIT_LAST);
    assign wait_state = (cur == S_FETCH) || (cur == S_MEMRD) || (cur == S_MEMWR);
    assign state      = cur;

    // opcode is only trusted in DECODE; remember lw vs sw for the MEMADR branch
    always_ff @(posedge clk) begin
        if (reset) begin
            cur   <= S_FETCH;
            cnt   <= '0;
            is_lw <= 1'b0;
        end else begin
            cur <= nxt;
            cnt <= cnt_nxt;
            if (cur == S_DECODE) begin
                is_lw <= (opcode == OP_LW);
            end
        end
    end

    always_comb begin
        nxt = S_FETCH;
        unique case (cur)
            S_FETCH:   nxt = wait_last ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (opcode == OP_RTYPE)                         nxt = S_EXEC;
                else if ((opcode == OP_LW) || (opcode == OP_SW)) nxt = S_MEMADR;
                else if (opcode == OP_BEQ)                      nxt = S_BRANCH;
                else if (opcode == OP_J)                        nxt = S_JUMP;
                else if (opcode == OP_ADDI)                     nxt = S_ADDI_EX;
                else                                            nxt = S_ILLEGAL;
            end
            S_MEMADR:  nxt = is_lw ? S_MEMRD : S_MEMWR;
            S_MEMRD:   nxt = wait_last ? S_MEMWB : S_MEMRD;
            S_MEMWB:   nxt = S_FETCH;
            S_MEMWR:   nxt = wait_last ? S_FETCH : S_MEMWR;
            S_EXEC:    nxt = S_RCOMP;
            S_RCOMP:   nxt = S_FETCH;
            S_BRANCH:  nxt = S_FETCH;
            S_JUMP:    nxt = S_FETCH;
            S_ADDI_EX: nxt = S_ADDI_WB;
            S_ADDI_WB: nxt = S_FETCH;
            S_ILLEGAL: nxt = S_ILLEGAL;
            default:   nxt = S_FETCH;
        endcase
    end

    // Counter only runs while a wait state re-enters itself; any state change
    // (including FETCH -> FETCH via MEMWR) lands with the counter cleared.
    always_comb begin
        cnt_nxt = '0;
        if (wait_state && (nxt == cur)) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUOp       = 2'b00;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        instr_done  = 1'b0;
        illegal     = 1'b0;
        unique case (cur)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = wait_last;
                PCWrite = wait_last;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg   = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = wait_last;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_RCOMP: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                instr_done  = 1'b1;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
            end
            S_ADDI_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDI_WB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_ILLEGAL: begin
                illegal = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_control_multi.sv
// Bench for control_multi: four instances with MEM_WAIT = 0..3. A model expands
// each instruction into its expected (state, last-wait-cycle) trace and maps
// each step to a control word; one negedge process checks the selected DUT.
module tb_control_multi;

    logic       clk = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       rst [4];
    logic [3:0] st_a  [4];
    logic [17:0] ctl_a [4];
    int         sel = 0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        logic pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, done, ill;
        logic [1:0] aluop, asb, pcs;
        control_multi #(.MEM_WAIT(g), .CNT_W(4)) u_dut (
            .clk(clk), .reset(rst[g]), .opcode(opcode),
            .PCWrite(pcw), .PCWriteCond(pcwc), .IorD(iord), .MemRead(mrd),
            .MemWrite(mwr), .MemtoReg(m2r), .IRWrite(irw), .ALUSrcA(asa),
            .RegWrite(rw), .RegDst(rd), .ALUOp(aluop), .ALUSrcB(asb),
            .PCSource(pcs), .state(st_a[g]), .instr_done(done), .illegal(ill)
        );
        assign ctl_a[g] = {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd,
                           aluop, asb, pcs, done, ill};
    end

    // bit positions in the control word
    localparam int B_RW = 9, B_DONE = 1, B_ILL = 0;

    typedef struct packed {
        logic [3:0] st;
        logic       last;
    } rec_t;

    rec_t exp_q[$];

    // control word a state must show: {PCWrite, PCWriteCond, IorD, MemRead,
    // MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst, ALUOp, ALUSrcB,
    // PCSource, instr_done, illegal}
    function automatic logic [17:0] exp_ctrl(input logic [3:0] s, input logic last);
        logic pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, done, ill;
        logic [1:0] aluop, asb, pcs;
        {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, done, ill} = '0;
        aluop = 2'b00; asb = 2'b00; pcs = 2'b00;
        case (s)
            4'd0:  begin mrd = 1; asb = 2'b01; irw = last; pcw = last; end
            4'd1:  asb = 2'b11;
            4'd2:  begin asa = 1; asb = 2'b10; end
            4'd3:  begin mrd = 1; iord = 1; end
            4'd4:  begin m2r = 1; rw = 1; done = 1; end
            4'd5:  begin mwr = 1; iord = 1; done = last; end
            4'd6:  begin asa = 1; aluop = 2'b10; end
            4'd7:  begin rd = 1; rw = 1; done = 1; end
            4'd8:  begin asa = 1; aluop = 2'b01; pcwc = 1; pcs = 2'b01; done = 1; end
            4'd9:  begin pcw = 1; pcs = 2'b10; done = 1; end
            4'd10: begin asa = 1; asb = 2'b10; end
            4'd11: begin rw = 1; done = 1; end
            4'd12: ill = 1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, aluop, asb, pcs, done, ill};
    endfunction

    function automatic void add_wait(input logic [3:0] s, input int w, inout rec_t o[$]);
        for (int i = 0; i <= w; i++) o.push_back('{st: s, last: (i == w)});
    endfunction

    // Trace of one instruction starting at FETCH cycle 0; an illegal opcode
    // contributes n_ill cycles of ILLEGAL.
    function automatic void build(input int w, input int op, input int n_ill, inout rec_t o[$]);
        o = {};
        add_wait(4'd0, w, o);
        o.push_back('{st: 4'd1, last: 1'b0});
        case (op)
            0:  begin o.push_back('{st: 4'd6, last: 1'b0}); o.push_back('{st: 4'd7, last: 1'b0}); end
            35: begin o.push_back('{st: 4'd2, last: 1'b0}); add_wait(4'd3, w, o);
                      o.push_back('{st: 4'd4, last: 1'b0}); end
            43: begin o.push_back('{st: 4'd2, last: 1'b0}); add_wait(4'd5, w, o); end
            4:  o.push_back('{st: 4'd8, last: 1'b0});
            2:  o.push_back('{st: 4'd9, last: 1'b0});
            8:  begin o.push_back('{st: 4'd10, last: 1'b0}); o.push_back('{st: 4'd11, last: 1'b0}); end
            default: for (int i = 0; i < n_ill; i++) o.push_back('{st: 4'd12, last: 1'b0});
        endcase
    endfunction

    int done_cnt = 0;
    int rw_cnt   = 0;

    always @(negedge clk) begin
        rec_t r;
        logic [17:0] e;
        if (ctl_a[sel][B_DONE] === 1'b1) done_cnt++;
        if (ctl_a[sel][B_RW] === 1'b1) rw_cnt++;
        if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            e = exp_ctrl(r.st, r.last);
            checks++;
            if (st_a[sel] !== r.st) begin
                errors++;
                $display("FAIL state w=%0d t=%0t: got %0d want %0d", sel, $time, st_a[sel], r.st);
            end
            checks++;
            if (ctl_a[sel] !== e) begin
                errors++;
                $display("FAIL ctrl w=%0d t=%0t state=%0d: got %b want %b", sel, $time, r.st, ctl_a[sel], e);
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic wait_empty();
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (exp_q.size() > 0 && n < 200);
        if (exp_q.size() > 0) begin
            check("trace timeout", exp_q.size(), 0);
            exp_q = {};
        end
    endtask

    task automatic do_reset(input int s);
        sel = s;
        @(posedge clk); #1;
        rst[s] = 1'b1;
        @(posedge clk); #1;
        rst[s] = 1'b0;
    endtask

    // must be entered at FETCH cycle 0 (one time unit after the edge)
    task automatic run_instr(input int op, input int n_ill);
        rec_t t[$];
        build(sel, op, n_ill, t);
        opcode   = 6'(op);
        done_cnt = 0;
        foreach (t[i]) exp_q.push_back(t[i]);
        wait_empty();
        if (n_ill == 0) check($sformatf("done pulses w=%0d op=%0d", sel, op), done_cnt, 1);
    endtask

    initial begin
        rec_t t[$];
        int   seq33[9] = '{0, 0, 0, 1, 2, 3, 3, 3, 4};

        for (int i = 0; i < 4; i++) rst[i] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) rst[i] = 1'b0;

        // hand-computed pins on the model: latencies and fixed control words
        build(0, 0, 0, t);  check("len rtype w0", t.size(), 4);
        build(2, 35, 0, t); check("len lw w2", t.size(), 9);
        foreach (seq33[i]) check($sformatf("lw w2 seq[%0d]", i), int'(t[i].st), seq33[i]);
        build(1, 43, 0, t); check("len sw w1", t.size(), 6);
        build(0, 4, 0, t);  check("len beq w0", t.size(), 3);
        build(0, 2, 0, t);  check("len j w0", t.size(), 3);
        build(3, 8, 0, t);  check("len addi w3", t.size(), 7);
        check("fetch last word", int'(exp_ctrl(4'd0, 1'b1)), 18'b100100100000010000);
        check("jump word", int'(exp_ctrl(4'd9, 1'b0)), 18'b100000000000001010);
        check("rcomp word", int'(exp_ctrl(4'd7, 1'b0)), 18'b000000001100000010);

        // MEM_WAIT = 0: R-type, beq, j, addi back to back, then lw, sw
        do_reset(0);
        run_instr(0, 0);
        run_instr(4, 0);
        run_instr(2, 0);
        run_instr(8, 0);
        run_instr(35, 0);
        run_instr(43, 0);

        // MEM_WAIT = 1 and 2
        do_reset(1);
        run_instr(43, 0);
        run_instr(35, 0);
        run_instr(0, 0);
        do_reset(2);
        run_instr(35, 0);
        run_instr(8, 0);

        // illegal opcode parks; reset recovers into FETCH with illegal low
        do_reset(0);
        run_instr(63, 10);
        check("illegal held", int'(ctl_a[0][B_ILL]), 1);
        do_reset(0);
        run_instr(0, 0);

        // MEM_WAIT = 3: reset lands while MEMRD cnt=1, lw must never write back
        do_reset(3);
        build(3, 35, 0, t);
        opcode = 6'd35;
        rw_cnt = 0;
        for (int i = 0; i < 8; i++) exp_q.push_back(t[i]);
        repeat (7) begin
            @(posedge clk); #1;
        end
        rst[3] = 1'b1;
        @(posedge clk); #1;
        rst[3] = 1'b0;
        check("abort trace consumed", exp_q.size(), 0);
        exp_q = {};
        check("abort regwrite", rw_cnt, 0);
        check("abort state", int'(st_a[3]), 0);
        run_instr(35, 0);
        check("lw after abort regwrite", rw_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
